// File: rtl/sim_clk_pkg.sv
// Shared constants and types for the simulation clock generator.
// Optional feature macro used by the design: SIM_CLK_GEN_PHASE_SYNC_EN.
package sim_clk_pkg;

   localparam int CNT_W_DEF = 16;

   // Half-periods in 50 MHz cycles for the two stock output frequencies.
   localparam logic [CNT_W_DEF-1:0] HP_100KHZ = 16'd250;
   localparam logic [CNT_W_DEF-1:0] HP_1KHZ   = 16'd25000;

   // Per-channel state at the default counter width.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] hp;
      logic [CNT_W_DEF-1:0] pending;
      logic [CNT_W_DEF-1:0] cnt;
   } chan_state_t;

   // Width of a channel-select field; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sim_clk_chan.sv
// One divided-clock channel: half-period counter, pending-update staging and
// registered clk_out / tick / pend.
// Macro SIM_CLK_GEN_PHASE_SYNC_EN adds the sync input that restarts the phase.
module sim_clk_chan #(
   parameter int               CNT_W   = 16,
   parameter logic [CNT_W-1:0] HP_INIT = '0
) (
   input  logic             clk_50Mhz,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr,
`ifdef SIM_CLK_GEN_PHASE_SYNC_EN
   input  logic             sync,
`endif
   input  logic [CNT_W-1:0] wr_hp,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef struct packed {
      logic [CNT_W-1:0] hp;
      logic [CNT_W-1:0] pending;
      logic [CNT_W-1:0] cnt;
   } state_t;

   state_t           st_q, st_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             pend_q, pend_d;
   logic             running;
   logic             restart;
   logic             toggle;
   logic [CNT_W-1:0] hp_next;

   assign running = en && (st_q.hp != '0);

   // A stopped channel (and, with phase sync, a sync pulse) drops back to a
   // fresh start: counter and output cleared, staged value applied.
`ifdef SIM_CLK_GEN_PHASE_SYNC_EN
   assign restart = !running || sync;
`else
   assign restart = !running;
`endif

   // Only meaningful when running, so hp >= 1 and hp-1 cannot wrap.
   assign toggle  = running && (st_q.cnt == st_q.hp - ONE);

   // Half-period taking effect at a boundary: a same-cycle write beats an
   // older staged value, which beats the current one.
   assign hp_next = wr ? wr_hp : (pend_q ? st_q.pending : st_q.hp);

   // Next-state: restart, half-period boundary, or plain count.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      st_d   = st_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      pend_d = pend_q;
      if (wr) begin
         st_d.pending = wr_hp;
      end
      if (restart) begin
         st_d.hp  = hp_next;
         st_d.cnt = '0;
         clk_d    = 1'b0;
         pend_d   = 1'b0;
      end else if (toggle) begin
         st_d.hp  = hp_next;
         st_d.cnt = '0;
         clk_d    = ~clk_q;
         tick_d   = ~clk_q;
         pend_d   = 1'b0;
      end else begin
         st_d.cnt = st_q.cnt + ONE;
         if (wr) begin
            pend_d = 1'b1;
         end
      end
   end

   // State register with asynchronous reset to the configured half-period.
   always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      if (!rst_n) begin
         st_q   <= '{hp: HP_INIT, pending: HP_INIT, cnt: '0};
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
         pend_q <= pend_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;
   assign pend    = pend_q;

endmodule

// File: rtl/sim_clock_gen.sv
// Multi-channel divided-clock generator running off the 50 MHz clock.
// Decodes half-period writes and instantiates one sim_clk_chan per channel.
// Macro SIM_CLK_GEN_PHASE_SYNC_EN enables the sync_i phase-realign input;
// without it sync_i is accepted but has no effect.
module sim_clock_gen
   import sim_clk_pkg::*;
#(
   parameter int                    N_CH   = 2,
   parameter int                    CNT_W  = CNT_W_DEF,
   parameter logic [N_CH*CNT_W-1:0] HP_RST = {HP_1KHZ, HP_100KHZ}
) (
   input  logic                     clk_50Mhz,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          en,
   input  logic                     wr_en,
   input  logic [sel_w(N_CH)-1:0]   wr_ch,
   input  logic [CNT_W-1:0]         wr_hp,
   input  logic                     sync_i,
   output logic [N_CH-1:0]          clk_out,
   output logic [N_CH-1:0]          tick,
   output logic [N_CH-1:0]          pend
);

   localparam int CH_W = sel_w(N_CH);

   logic [N_CH-1:0] wr_sel;

   // One-hot write select; a channel number beyond N_CH matches nothing.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         wr_sel[i] = wr_en && (wr_ch == CH_W'(i));
      end
   end

`ifndef SIM_CLK_GEN_PHASE_SYNC_EN
   logic unused_sync;
   assign unused_sync = sync_i;
`endif

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      sim_clk_chan #(
         .CNT_W   (CNT_W),
         .HP_INIT (HP_RST[g*CNT_W +: CNT_W])
      ) u_chan (
         .clk_50Mhz (clk_50Mhz),
         .rst_n     (rst_n),
         .en        (en[g]),
         .wr        (wr_sel[g]),
`ifdef SIM_CLK_GEN_PHASE_SYNC_EN
         .sync      (sync_i),
`endif
         .wr_hp     (wr_hp),
         .clk_out   (clk_out[g]),
         .tick      (tick[g]),
         .pend      (pend[g])
      );
   end

endmodule

// File: tb/tb_sim_clock_gen.sv
// Self-checking bench for sim_clock_gen: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model. The model treats
// each half-period as a number of remaining cycles. Three channels are built
// so that a write to channel 3 exercises the out-of-range path.
`timescale 1ns/1ps
module tb_sim_clock_gen;
   import sim_clk_pkg::*;

   localparam int N = 3;
   localparam int W = CNT_W_DEF;
   localparam logic [N*W-1:0] HP_INIT = {16'd7, HP_1KHZ, HP_100KHZ};
`ifdef SIM_CLK_GEN_PHASE_SYNC_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   logic         clk_50Mhz = 1'b0;
   logic         rst_n;
   logic [N-1:0] en;
   logic         wr_en;
   logic [1:0]   wr_ch;
   logic [W-1:0] wr_hp;
   logic         sync_i;
   logic [N-1:0] clk_out;
   logic [N-1:0] tick;
   logic [N-1:0] pend;

   always #10 clk_50Mhz = ~clk_50Mhz;

   sim_clock_gen #(
      .N_CH   (N),
      .CNT_W  (W),
      .HP_RST (HP_INIT)
   ) dut (
      .clk_50Mhz (clk_50Mhz),
      .rst_n     (rst_n),
      .en        (en),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_hp     (wr_hp),
      .sync_i    (sync_i),
      .clk_out   (clk_out),
      .tick      (tick),
      .pend      (pend)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int tick_cnt [N];

   // Reference model state per channel.
   int m_hp   [N];
   bit m_pv   [N];
   int m_pval [N];
   int m_rem  [N];   // cycles left in the current half; 0 = not started
   bit m_lvl  [N];
   bit m_tk   [N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      logic [N*W-1:0] init_v;
      init_v = HP_INIT;
      for (int ch = 0; ch < N; ch++) begin
         m_hp[ch]   = int'(init_v[ch*W +: W]);
         m_pv[ch]   = 1'b0;
         m_pval[ch] = 0;
         m_rem[ch]  = 0;
         m_lvl[ch]  = 1'b0;
         m_tk[ch]   = 1'b0;
      end
   endtask

   // One rising edge of the model, using the inputs the DUT just sampled.
   task automatic model_step();
      for (int ch = 0; ch < N; ch++) begin
         bit w;
         int whp;
         w   = wr_en && (int'(wr_ch) == ch);
         whp = int'(wr_hp);
         m_tk[ch] = 1'b0;
         if (!en[ch] || m_hp[ch] == 0 || (SYNC_ON && sync_i)) begin
            if (w)              m_hp[ch] = whp;
            else if (m_pv[ch])  m_hp[ch] = m_pval[ch];
            m_pv[ch]  = 1'b0;
            m_rem[ch] = 0;
            m_lvl[ch] = 1'b0;
         end else begin
            if (m_rem[ch] == 0) m_rem[ch] = m_hp[ch];
            m_rem[ch]--;
            if (m_rem[ch] == 0) begin
               m_lvl[ch] = !m_lvl[ch];
               m_tk[ch]  = m_lvl[ch];
               if (w)             m_hp[ch] = whp;
               else if (m_pv[ch]) m_hp[ch] = m_pval[ch];
               m_pv[ch] = 1'b0;
            end else if (w) begin
               m_pv[ch]   = 1'b1;
               m_pval[ch] = whp;
            end
         end
      end
   endtask

   // Advance one clock, update the model, compare all outputs at the negedge.
   task automatic cycle();
      logic [3*N-1:0] e;
      @(posedge clk_50Mhz);
      if (!rst_n) model_reset();
      else        model_step();
      cyc++;
      @(negedge clk_50Mhz);
      for (int ch = 0; ch < N; ch++) begin
         e[2*N + ch] = m_lvl[ch];
         e[N + ch]   = m_tk[ch];
         e[ch]       = m_pv[ch];
         if (tick[ch]) tick_cnt[ch]++;
      end
      check("cycle", 32'({clk_out, tick, pend}), 32'(e));
   endtask

   task automatic do_write(input int ch, input int hp);
      wr_en = 1'b1;
      wr_ch = 2'(ch);
      wr_hp = W'(hp);
      cycle();
      wr_en = 1'b0;
   endtask

   // Cycles until the next tick on ch, capped at bound.
   task automatic wait_tick(input int ch, input int bound, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!tick[ch] && n < bound);
   endtask

   // Cycles until clk_out[ch] equals lvl (returns bound if never).
   task automatic wait_level(input int ch, input bit lvl, input int bound, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (clk_out[ch] !== lvl && n < bound);
   endtask

   initial begin
      int n, t0, t1, prev, trans, tk0;
      rst_n  = 1'b1;
      en     = 3'b011;
      wr_en  = 1'b0;
      wr_ch  = '0;
      wr_hp  = '0;
      sync_i = 1'b0;
      for (int ch = 0; ch < N; ch++) tick_cnt[ch] = 0;
      model_reset();

      // Reset state.
      #2 rst_n = 1'b0;
      #1;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_pend", 32'(pend), 32'd0);
      @(negedge clk_50Mhz);
      @(negedge clk_50Mhz);
      rst_n = 1'b1;
      cyc   = 0;

      // Default half-periods after release.
      wait_tick(0, 400, n);
      check("ch0_first_rise", n, 250);
      check("ch0_rise_tick", 32'({clk_out[0], tick[0]}), 32'b11);
      wait_tick(0, 700, n);
      check("ch0_period", n, 500);
      tk0 = tick_cnt[0];
      wait_tick(1, 26000, n);
      check("ch1_first_rise", cyc, 25000);
      check("ch0_ticks_per_rise", tick_cnt[0] - tk0, 48);

      // Write mid-half on a running channel: staged until the next toggle.
      wait_tick(0, 600, n);
      repeat (99) cycle();
      do_write(0, 10);
      check("pend_set", 32'(pend[0]), 32'd1);
      wait_level(0, 1'b0, 300, n);
      check("half_completes", 100 + n, 250);
      check("pend_clear", 32'(pend[0]), 32'd0);
      wait_tick(0, 50, n);
      check("new_half", n, 10);

      // Write coincident with a toggle: applies immediately, no pend.
      repeat (9) cycle();
      do_write(0, 4);
      check("coinc_fall", 32'(clk_out[0]), 32'd0);
      check("coinc_no_pend", 32'(pend[0]), 32'd0);
      wait_tick(0, 50, n);
      check("coinc_half", n, 4);

      // hp = 1 divides by two, then hp = 0 holds low.
      en[0] = 1'b0;
      cycle();
      do_write(0, 1);
      check("stopped_write_no_pend", 32'(pend[0]), 32'd0);
      en[0] = 1'b1;
      tk0   = tick_cnt[0];
      prev  = int'(clk_out[0]);
      trans = 0;
      repeat (8) begin
         cycle();
         if (int'(clk_out[0]) != prev) trans++;
         prev = int'(clk_out[0]);
      end
      check("div2_ticks", tick_cnt[0] - tk0, 4);
      check("div2_toggles", trans, 8);
      do_write(0, 0);
      tk0 = tick_cnt[0];
      repeat (10) cycle();
      check("hp0_no_ticks", tick_cnt[0] - tk0, 0);
      check("hp0_low", 32'(clk_out[0]), 32'd0);

      // en falling mid-high clears; re-enable restarts from zero.
      en[0] = 1'b0;
      cycle();
      do_write(0, 6);
      en[0] = 1'b1;
      wait_tick(0, 20, n);
      check("hp6_rise", n, 6);
      cycle();
      en[0] = 1'b0;
      cycle();
      check("en_fall_clk", 32'({clk_out[0], tick[0]}), 32'd0);
      en[0] = 1'b1;
      wait_tick(0, 20, n);
      check("reenable_rise", n, 6);

      // Asynchronous reset mid-period.
      repeat (3) cycle();
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_clk", 32'(clk_out), 32'd0);
      check("async_rst_tick_pend", 32'({tick, pend}), 32'd0);
      model_reset();
      cycle();
      rst_n = 1'b1;
      wait_tick(0, 400, n);
      check("post_reset_rise", n, 250);

      // Out-of-range write and phase sync on two offset channels at hp 7.
      en = '0;
      cycle();
      do_write(0, 7);
      do_write(1, 7);
      do_write(3, 2);
      en = 3'b001;
      repeat (3) cycle();
      en = 3'b011;
      cycle();
      sync_i = 1'b1;
      cycle();
      sync_i = 1'b0;
      t0 = 0;
      t1 = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (tick[0] && t0 == 0) t0 = i;
         if (tick[1] && t1 == 0) t1 = i;
      end
      check("sync_ch0_rise", t0, SYNC_ON ? 7 : 2);
      check("sync_ch1_rise", t1, SYNC_ON ? 7 : 5);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) en = N'($urandom);
         wr_en  = ($urandom_range(0, 5) == 0);
         wr_ch  = 2'($urandom_range(0, 3));
         wr_hp  = ($urandom_range(0, 19) == 0) ? 16'hFFFF : W'($urandom_range(0, 9));
         sync_i = ($urandom_range(0, 30) == 0);
         cycle();
      end
      wr_en  = 1'b0;
      sync_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
